// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU main control: states, opcodes,
// ALU/mux selects and the packed control word.
package cpu_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC_R = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_EXEC_I = 4'd11;
    localparam logic [3:0] S_IWB    = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd13;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b0110;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_SLTI  = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_control_unit_if #(parameter int CNT_W = 16);
    logic             opcode_unused_guard;
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic [3:0]       state_o;
    logic             illegal_op;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    assign opcode_unused_guard = 1'b0;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state_o, illegal_op, halted, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state_o, illegal_op, halted, instr_count
    );
endinterface

// File: rtl/control_output_decoder.sv
// Moore output decode: state (plus mem_ready for the fetch strobes) -> control word.
module control_output_decoder
    import cpu_pkg::*;
#(
    parameter logic [1:0] PC_INC = 2'b01
) (
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = PC_INC;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only advance on the cycle the read completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BROFF;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ITYPE;
            end
            S_IWB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the 16-bit multicycle CPU: sequences fetch/decode/execute/
// memory/writeback, stalls on mem_ready and counts retired instructions.
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int         CNT_W  = 16,
    parameter logic [1:0] PC_INC = 2'b01
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_unit_if.master bus
);

    logic [3:0]       state;
    logic [3:0]       next_state;
    logic             retire;
    logic             illegal;
    logic [CNT_W-1:0] count;
    ctrl_t            ctrl;
    logic             unused_zero;

    // zero only qualifies PCWriteCond inside the datapath
    assign unused_zero = bus.zero;

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                        next_state = S_EXEC_R;
                    OP_LW, OP_SW:                    next_state = S_MEMADR;
                    OP_BEQ:                          next_state = S_BRANCH;
                    OP_J:                            next_state = S_JUMP;
                    OP_SLL, OP_SRA, OP_ADDI,
                    OP_SUBI, OP_SLTI:                next_state = S_EXEC_I;
                    OP_HALT:                         next_state = S_HALT;
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: next_state = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) next_state = S_MEMWB;
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_EXEC_R: next_state = S_RWB;
            S_EXEC_I: next_state = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            if (retire) count <= count + 1'b1;
        end
    end

    control_output_decoder #(.PC_INC(PC_INC)) u_dec (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.halted      = ctrl.halted;
    assign bus.state_o     = state;
    assign bus.illegal_op  = illegal;
    assign bus.instr_count = count;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style main control FSM for the 16-bit multicycle CPU.
- Sequences fetch/decode/execute/memory/writeback over shared PC, IR, register file, memory port and single ALU.
- Drives the 2-bit ALUOp consumed by the ALU control decoder; Funct is decoded there, not here.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- PC_INC, 2'b01, ALUSrcB select for the PC increment constant (word-addressed PC+1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  4  IR[15:12], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by zero
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  0 = ALUOut, 1 = MDR to register write data
- RegDst  out  1  0 = rt, 1 = rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = PC_INC const, 10 = sign-ext imm, 11 = sign-ext imm (branch offset)
- ALUOp  out  2  00 add, 01 sub, 10 R-type (use Funct), 11 I-format (use opcode)
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state_o  out  4  current state, debug
- illegal_op  out  1  one-cycle pulse on undefined opcode
- halted  out  1  high in HALT
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Opcode map:
  - 0000 R-type
  - 0001 LW
  - 0011 SW
  - 0100 BEQ
  - 0101 J
  - 0010 SLL
  - 0110 SRA
  - 1001 ADDI
  - 1010 SUBI
  - 1011 SLTI
  - 1111 HALT
  - All other opcodes are illegal.
- States (4-bit): IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC_R=7, RWB=8, BRANCH=9, JUMP=10, EXEC_I=11, IWB=12, HALT=13.
- Reset: async to IDLE, instr_count=0, all outputs 0 (ALUOp=00, ALUSrcB=00, PCSource=00).
- IDLE: all outputs 0. Goes to FETCH next cycle.
- FETCH:
  - Asserts MemRead, IorD=0, ALUSrcA=0, ALUSrcB=PC_INC, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1. When mem_ready=1, go to DECODE; otherwise stay in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state: 0000 -> EXEC_R; LW/SW -> MEMADR; BEQ -> BRANCH; J -> JUMP; SLL/SRA/ADDI/SUBI/SLTI -> EXEC_I; HALT -> HALT.
  - Illegal opcode: illegal_op=1 for that cycle, go to FETCH; instr_count is not incremented.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH and increments the counter.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH and increments the counter.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH and increments the counter.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Goes to IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH and increments the counter.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH and increments the counter, whether or not the branch is taken.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH and increments the counter.
- HALT: halted=1, all enables 0. Stays in HALT until reset.
- Any unencoded state value: go to IDLE.
- Latency in cycles with zero wait states:
  - R-type, I-format: 4
  - BEQ, J: 3
  - LW: 5
  - SW: 4
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- MemRead/MemWrite stay asserted, with IorD stable, through the whole wait.
- Other outputs:
  - instr_count is registered. It increments on the clock edge that leaves the final state of an instruction, then wraps, e.g. 16'hFFFF -> 16'h0000.
  - All control outputs are a combinational function of the state register plus mem_ready. There are no Mealy dependencies on opcode except illegal_op in DECODE.
- Reset asserted mid-wait (e.g. MEMWR) drops MemWrite to 0 immediately and asynchronously.

Decomposition:
- cpu_pkg holds:
  - state enum / localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_SLL, OP_SRA, OP_ADDI, OP_SUBI, OP_SLTI, OP_HALT)
  - ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ITYPE)
  - ALUSrcB/PCSource select constants
- One natural sub-module: control_output_decoder (state, mem_ready -> control word). The FSM and counter stay in the top.

Test Plan:
- Reset, then release with mem_ready=1 and opcode=0000:
  - state_o sequence 0,1,2,7,8,1.
  - ALUOp=10 in EXEC_R; RegWrite=1 and RegDst=1 in RWB.
  - instr_count=1.
- opcode=0001 (LW) with mem_ready held 0 for 3 cycles in MEMRD:
  - MemRead=1 and IorD=1 for 4 cycles.
  - Then MEMWB with MemtoReg=1; total 8 cycles; instr_count increments by 1.
- opcode=0100 (BEQ), zero=1 then zero=0:
  - PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH in both runs.
  - Back to FETCH after 3 cycles each.
- opcode=1010 (SUBI): ALUOp=11, ALUSrcB=10 in EXEC_I; RegWrite=1, RegDst=0 in IWB.
- opcode=0111 (illegal): illegal_op pulses 1 cycle in DECODE, FETCH next, instr_count unchanged.
- Counter and reset:
  - Preload instr_count to 16'hFFFF via 65535 J instructions, or force in sim; one more J gives 16'h0000.
  - opcode=1111: halted=1 and held.
  - Async reset asserted mid-MEMWR: MemWrite=0 before the next clk edge; state_o=0.
